// File: rtl/pkt_tx_serializer_pkg.sv
// pkt_tx_serializer_pkg: packet types, frame constants and entry layout shared by the serializer and its FIFO
package pkt_tx_serializer_pkg;
  typedef enum logic [2:0] {HB, CHE, INV, MR, CHT, DATA, SOS, INVALID} pkt_type_t;
  localparam int PKT_WORDS = 8;
  localparam logic [7:0] HDR_LEN = 8'(PKT_WORDS);
  localparam int FIELD_W = 16;
  typedef struct packed {
    pkt_type_t ptype;
    logic [PKT_WORDS-2:0][FIELD_W-1:0] fields;
  } tx_entry_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_BACKOFF} state_t;
endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: synchronous FIFO with wrap-bit pointers; a push while full is accepted when a pop happens in the same cycle
module pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/pkt_tx_serializer.sv
// pkt_tx_serializer: queues reward field sets and sends each as 8 words with carrier sense and inter-frame gap; TX_BACKOFF_EN adds LFSR random backoff
module pkt_tx_serializer import pkt_tx_serializer_pkg::*; #(
  parameter int WORD_WIDTH = 16,
  parameter int PKT_DEPTH  = 4,
  parameter int IFS_CYCLES = 2
`ifdef TX_BACKOFF_EN
  , parameter logic [7:0] BACKOFF_MASK = 8'h1F
`endif
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  reward_done,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  channel_busy,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic                  fifo_full,
  output logic [7:0]            drop_cnt
);
  localparam int EW = 3 + (PKT_WORDS-1)*WORD_WIDTH;
  localparam logic [2:0] LAST = 3'(PKT_WORDS-1);
  state_t state_q, state_d;
  logic [EW-1:0] entry, head, hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gap_q, gap_d, drop_q, drop_d;
  logic cap, pop, empty;
  logic [PKT_WORDS-1:0][WORD_WIDTH-1:0] words;
  assign cap   = reward_done && rPacketType != INVALID;
  assign entry = {rPacketType, rSourceID, rDestinationID, rEnergyLeft, rQValue, rSourceHops, rChosenCH, rHopsFromCH};
  pkt_fifo #(.WIDTH(EW), .DEPTH(PKT_DEPTH)) u_fifo (
    .clk(clk), .nrst(nrst), .push_i(cap), .pop_i(pop), .din_i(entry),
    .dout_o(head), .full_o(fifo_full), .empty_o(empty)
  );
  always_comb begin
    words[0] = {hold_q[EW-1 -: 3], {(WORD_WIDTH-11){1'b0}}, HDR_LEN};
    for (int k = 1; k < PKT_WORDS; k++) words[k] = hold_q[(PKT_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH];
  end
  assign tx_valid = state_q == S_SEND;
  assign tx_data  = tx_valid ? words[idx_q] : '0;
  assign tx_sop   = tx_valid && idx_q == 3'd0;
  assign tx_eop   = tx_valid && idx_q == LAST;
  assign busy     = state_q != S_IDLE || !empty;
  assign drop_cnt = drop_q;
  assign drop_d   = drop_q + 8'(cap && fifo_full && !pop && drop_q != 8'hFF);
`ifdef TX_BACKOFF_EN
  logic [7:0] lfsr_q;
  logic [8:0] bo_q, bo_d, bo_new;
  assign bo_new = {1'b0, lfsr_q & BACKOFF_MASK} + 9'd1;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      lfsr_q <= 8'hA5;
      bo_q   <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      bo_q   <= bo_d;
    end
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    pop     = 1'b0;
`ifdef TX_BACKOFF_EN
    bo_d    = bo_q;
`endif
    unique case (state_q)
      S_IDLE:
        if (!empty && !channel_busy) begin
`ifdef TX_BACKOFF_EN
          bo_d    = bo_new;
          state_d = S_BACKOFF;
`else
          pop     = 1'b1;
          hold_d  = head;
          idx_d   = '0;
          state_d = S_SEND;
`endif
        end
      S_SEND:
        if (tx_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == LAST) begin
            gap_d   = 8'(IFS_CYCLES);
            state_d = S_GAP;
          end
        end
      S_GAP: begin
        gap_d   = gap_q - 8'd1;
        state_d = gap_q <= 8'd1 ? S_IDLE : S_GAP;
      end
      S_BACKOFF: begin
`ifdef TX_BACKOFF_EN
        // the head stays queued until the channel is won, so the pop happens here
        if (channel_busy) bo_d = bo_q == '0 ? bo_new : bo_q;
        else if (bo_q != '0) bo_d = bo_q - 9'd1;
        else begin
          pop     = 1'b1;
          hold_d  = head;
          idx_d   = '0;
          state_d = S_SEND;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
endmodule

// File: tb/tb_pkt_tx_serializer.sv
// tb_pkt_tx_serializer: directed self-checking bench for pkt_tx_serializer in its default build
module tb_pkt_tx_serializer;
  logic clk = 1'b0, nrst = 1'b0, reward_done = 1'b0, channel_busy = 1'b0, tx_ready = 1'b1;
  logic [2:0] rPacketType = '0;
  logic [15:0] rSourceID = '0, rDestinationID = '0, rEnergyLeft = '0, rQValue = '0;
  logic [15:0] rSourceHops = '0, rChosenCH = '0, rHopsFromCH = '0;
  logic tx_valid, tx_sop, tx_eop, busy, fifo_full;
  logic [15:0] tx_data;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pkt_tx_serializer dut (
    .clk(clk), .nrst(nrst), .reward_done(reward_done), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rEnergyLeft(rEnergyLeft),
    .rQValue(rQValue), .rSourceHops(rSourceHops), .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
    .channel_busy(channel_busy), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [2:0] t, input logic [111:0] f);
    rPacketType = t;
    {rSourceID, rDestinationID, rEnergyLeft, rQValue, rSourceHops, rChosenCH, rHopsFromCH} = f;
    reward_done = 1'b1;
  endtask
  task automatic cap(input logic [2:0] t, input logic [111:0] f);
    drive(t, f);
    @(negedge clk);
    reward_done = 1'b0;
  endtask
  // e holds the 8 expected words, word 0 in the top 16 bits
  task automatic recv(input string tag, input logic [127:0] e, input logic [3:0] pat);
    int i = 0, k = 0, t = 0;
    while (i < 8 && t < 200) begin
      if (tx_valid) begin
        check({tag, "_data"}, tx_data, e[127-16*i -: 16]);
        check({tag, "_sop"}, tx_sop, i == 0);
        check({tag, "_eop"}, tx_eop, i == 7);
        tx_ready = pat[k%4];
        k++;
        if (tx_ready) i++;
      end
      t++;
      @(negedge clk);
    end
    if (i < 8) check({tag, "_timeout"}, i, 8);
    tx_ready = 1'b1;
  endtask
  function automatic logic [111:0] seq_fields(input logic [15:0] j);
    logic [111:0] f;
    for (int k = 0; k < 7; k++) f[111-16*k -: 16] = 16'((k+1) << 12) | j;
    return f;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [111:0] f1, fa;
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    // single DATA packet, idle channel, always ready
    f1 = {16'h0003, 16'h0001, 16'h0800, 16'h0001, 16'h0002, 16'h0003, 16'h0003};
    cap(3'd5, f1);
    check("lat1_valid", tx_valid, 0);
    @(negedge clk);
    check("lat2_valid", tx_valid, 1);
    recv("p1", {16'hA008, f1}, 4'b1111);
    check("gap1_valid", tx_valid, 0);
    check("gap1_busy", busy, 1);
    @(negedge clk);
    check("gap2_valid", tx_valid, 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    // invalid type is ignored
    cap(3'd7, f1);
    for (int c = 0; c < 4; c++) begin
      check("inv_valid", tx_valid, 0);
      check("inv_busy", busy, 0);
      @(negedge clk);
    end
    check("inv_full", fifo_full, 0);
    check("inv_drop", drop_cnt, 0);
    // six back-to-back captures against a busy channel
    channel_busy = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 3) check("full_at3", fifo_full, 0);
      if (j == 4) check("full_at4", fifo_full, 1);
      drive(3'(j), seq_fields(16'(j)));
      @(negedge clk);
    end
    reward_done = 1'b0;
    check("ovf_drop", drop_cnt, 2);
    check("ovf_full", fifo_full, 1);
    check("ovf_valid", tx_valid, 0);
    channel_busy = 1'b0;
    recv("q0", {16'h0008, seq_fields(16'd0)}, 4'b1111);
    recv("q1", {16'h2008, seq_fields(16'd1)}, 4'b1111);
    recv("q2", {16'h4008, seq_fields(16'd2)}, 4'b1111);
    recv("q3", {16'h6008, seq_fields(16'd3)}, 4'b1111);
    check("drain_full", fifo_full, 0);
    check("drain_drop", drop_cnt, 2);
    // tx_ready toggling 1,0,0,1 while sending
    cap(3'd5, {16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06, 16'h0B07});
    recv("stall", {16'hA008, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06, 16'h0B07}, 4'b1001);
    // reset in the middle of a frame with a second packet queued
    for (int c = 0; c < 4; c++) @(negedge clk);
    fa = {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5, 16'h00A6, 16'h00A7};
    cap(3'd6, fa);
    cap(3'd1, f1);
    for (int t = 0; t < 20 && !tx_valid; t++) @(negedge clk);
    check("mid_w0", tx_data, 16'hC008);
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("mid_w4", tx_data, 16'h00A4);
    nrst = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_data", tx_data, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", tx_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    check("post_rst_drop", drop_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
